// File: rtl/pm32_share_ctrl.sv
// pm32_share_ctrl: round-robin arbiter sharing one external combinational
// 32x32 multiplier (pm32) among NREQ requesters. Operands are registered and
// held for MUL_LAT cycles (multicycle path), then the 64-bit product is
// captured and returned over a valid/ready handshake.
module pm32_share_ctrl #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic [NREQ-1:0]      gnt,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic [63:0]          mul_c,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [63:0]          rsp_c,
    output logic                 busy,
    output logic [31:0]          op_count
);

    localparam int unsigned CNTW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam int unsigned SW   = IDW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [IDW-1:0]    ptr, ptr_nx;
    logic [CNTW-1:0]   cnt, cnt_nx;
    logic [NREQ-1:0]   gnt_nx;
    logic [31:0]       mul_a_nx, mul_b_nx;
    logic              rsp_valid_nx;
    logic [IDW-1:0]    rsp_id_nx;
    logic [63:0]       rsp_c_nx;
    logic              busy_nx;
    logic [31:0]       op_count_nx;

    logic              any_req;
    logic [IDW-1:0]    win_id;
    logic [31:0]       win_a, win_b;

    // (base + off) mod NREQ; both inputs are below NREQ so one subtract suffices
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        logic [SW-1:0] s;
        s = {1'b0, base} + SW'(off);
        if (s >= SW'(NREQ)) begin
            s = s - SW'(NREQ);
        end
        return s[IDW-1:0];
    endfunction

    // Round-robin winner: first set request at or after ptr, wrapping
    always_comb begin
        win_id  = ptr;
        any_req = |req;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (req[wrap_add(ptr, k)]) begin
                win_id = wrap_add(ptr, k);
            end
        end
        win_a = req_a[32*int'(win_id) +: 32];
        win_b = req_b[32*int'(win_id) +: 32];
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        cnt_nx       = cnt;
        gnt_nx       = '0;
        mul_a_nx     = mul_a;
        mul_b_nx     = mul_b;
        rsp_valid_nx = rsp_valid;
        rsp_id_nx    = rsp_id;
        rsp_c_nx     = rsp_c;
        op_count_nx  = op_count;

        unique case (state)
            ST_IDLE: begin
                if (any_req) begin
                    mul_a_nx       = win_a;
                    mul_b_nx       = win_b;
                    gnt_nx[win_id] = 1'b1;
                    rsp_id_nx      = win_id;
                    cnt_nx         = CNTW'(MUL_LAT - 1);
                    state_nx       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    rsp_c_nx     = mul_c;
                    rsp_valid_nx = 1'b1;
                    state_nx     = ST_DONE;
                end else begin
                    cnt_nx = cnt - CNTW'(1);
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_nx = 1'b0;
                    ptr_nx       = wrap_add(rsp_id, 1);
                    op_count_nx  = op_count + 32'd1;
                    state_nx     = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

    // State and output registers; reset wins over grant and accept
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_c     <= '0;
            busy      <= 1'b0;
            op_count  <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            cnt       <= cnt_nx;
            gnt       <= gnt_nx;
            mul_a     <= mul_a_nx;
            mul_b     <= mul_b_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_id    <= rsp_id_nx;
            rsp_c     <= rsp_c_nx;
            busy      <= busy_nx;
            op_count  <= op_count_nx;
        end
    end

endmodule

// File: tb/tb_pm32_share_ctrl.sv
// Testbench for pm32_share_ctrl: requester agents with operand queues drive
// the DUT; a cycle-level reference model predicts every output, grants push
// expected results into a scoreboard that is popped on each accepted response.
module tb_pm32_share_ctrl;

    localparam int NR  = 4;
    localparam int LAT = 2;
    localparam int IDW = 2;
    localparam int QD  = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NR-1:0]       req;
    logic [NR*32-1:0]    req_a, req_b;
    logic [NR-1:0]       gnt;
    logic [31:0]         mul_a, mul_b;
    logic [63:0]         mul_c;
    logic                rsp_valid, rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [63:0]         rsp_c;
    logic                busy;
    logic [31:0]         op_count;

    // pm32 stand-in
    assign mul_c = 64'(mul_a) * 64'(mul_b);

    pm32_share_ctrl #(.NREQ(NR), .MUL_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_c(rsp_c), .busy(busy), .op_count(op_count)
    );

    // second instance for the MUL_LAT=1 corner
    logic [NR-1:0]       l1_req;
    logic [NR*32-1:0]    l1_req_a, l1_req_b;
    logic [NR-1:0]       l1_gnt;
    logic [31:0]         l1_mul_a, l1_mul_b;
    logic [63:0]         l1_mul_c;
    logic                l1_rsp_valid;
    logic                l1_rsp_ready;
    logic [IDW-1:0]      l1_rsp_id;
    logic [63:0]         l1_rsp_c;
    logic                l1_busy;
    logic [31:0]         l1_op_count;

    assign l1_mul_c = 64'(l1_mul_a) * 64'(l1_mul_b);

    pm32_share_ctrl #(.NREQ(NR), .MUL_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .req(l1_req), .req_a(l1_req_a), .req_b(l1_req_b),
        .gnt(l1_gnt), .mul_a(l1_mul_a), .mul_b(l1_mul_b), .mul_c(l1_mul_c),
        .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_id(l1_rsp_id),
        .rsp_c(l1_rsp_c), .busy(l1_busy), .op_count(l1_op_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // requester agents: per-requester operand queues
    logic [31:0] op_a [NR][QD];
    logic [31:0] op_b [NR][QD];
    int hd [NR];
    int tl [NR];

    task automatic push_op(input int i, input logic [31:0] a, input logic [31:0] b);
        op_a[i][tl[i]] = a;
        op_b[i][tl[i]] = b;
        tl[i]++;
    endtask

    function automatic bit agents_empty();
        for (int i = 0; i < NR; i++) begin
            if (hd[i] != tl[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // driver: present the head operation of each agent just after each edge
    initial begin
        for (int i = 0; i < NR; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        req   = '0;
        req_a = '0;
        req_b = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                req[i] = (hd[i] != tl[i]);
                if (hd[i] != tl[i]) begin
                    req_a[i*32 +: 32] = op_a[i][hd[i]];
                    req_b[i*32 +: 32] = op_b[i][hd[i]];
                end
            end
        end
    end

    // reference model state
    typedef struct packed {
        logic [IDW-1:0] id;
        logic [63:0]    c;
    } exp_t;

    exp_t          sb[$];
    int            gq[$];
    int            m_phase = 0;   // 0 idle, 1 computing, 2 result held
    int            m_cnt   = 0;
    int            m_ptr   = 0;
    logic [IDW-1:0] m_id   = '0;
    logic [31:0]   m_a     = '0;
    logic [31:0]   m_b     = '0;
    logic [63:0]   m_c     = '0;
    logic [63:0]   m_prod  = '0;
    logic [31:0]   m_ops   = '0;
    logic [NR-1:0] exp_gnt = '0;

    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++) begin
            if (r[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    // monitor: compare outputs with the model, pop the scoreboard on accept,
    // then advance the model across the coming edge
    initial begin
        int   w;
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("gnt",       64'(gnt),       64'(exp_gnt));
            check("busy",      64'(busy),      64'(m_phase != 0));
            check("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
            check("mul_a",     64'(mul_a),     64'(m_a));
            check("mul_b",     64'(mul_b),     64'(m_b));
            check("rsp_id",    64'(rsp_id),    64'(m_id));
            check("rsp_c",     rsp_c,          m_c);
            check("op_count",  64'(op_count),  64'(m_ops));
            for (int k = 0; k < NR; k++) begin
                if (gnt[k]) gq.push_back(k);
            end
            if (rsp_valid && rsp_ready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sb_id", 64'(rsp_id), 64'(e.id));
                    check("sb_c",  rsp_c,       e.c);
                end
            end

            exp_gnt = '0;
            if (rst) begin
                m_phase = 0; m_cnt = 0; m_ptr = 0; m_id = '0;
                m_a = '0; m_b = '0; m_c = '0; m_ops = '0;
                sb.delete();
            end else if (m_phase == 0) begin
                if (req != '0) begin
                    w = pick(req, m_ptr);
                    exp_gnt[w] = 1'b1;
                    m_a    = req_a[w*32 +: 32];
                    m_b    = req_b[w*32 +: 32];
                    m_id   = IDW'(w);
                    m_prod = 64'(m_a) * 64'(m_b);
                    sb.push_back('{id: IDW'(w), c: m_prod});
                    m_cnt   = LAT;
                    m_phase = 1;
                    if (hd[w] != tl[w]) hd[w]++;
                end
            end else if (m_phase == 1) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_phase = 2;
                    m_c     = m_prod;
                end
            end else begin
                if (rsp_ready) begin
                    m_phase = 0;
                    m_ptr   = (int'(m_id) + 1) % NR;
                    m_ops   = m_ops + 32'd1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        bit done;
        done = 1'b0;
        for (int n = 0; n < max_cyc && !done; n++) begin
            cyc();
            if (agents_empty() && m_phase == 0 && !rsp_valid) done = 1'b1;
        end
        check("drain_done", 64'(done), 64'(1));
    endtask

    task automatic check_order(input string name, input int exp_q[$]);
        check({name, "_len"}, 64'(gq.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < gq.size(); i++) begin
            check(name, 64'(gq[i]), 64'(exp_q[i]));
        end
    endtask

    // stimulus
    initial begin
        bit seen;
        rst          = 1'b1;
        rsp_ready    = 1'b1;
        l1_req       = '0;
        l1_req_a     = '0;
        l1_req_b     = '0;
        l1_rsp_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_rsp_c",    rsp_c,             64'h0);
        check("rst_op_count", 64'(op_count),     64'h0);
        check("l1_rst_busy",  64'(l1_busy),      64'h0);
        check("l1_rst_valid", 64'(l1_rsp_valid), 64'h0);

        // single request
        cyc();
        push_op(0, 32'h1, 32'h2);
        drain(50);
        check("single_ops", 64'(op_count), 64'd1);

        // four simultaneous requests from ptr=0
        do_reset();
        gq.delete();
        push_op(0, 32'h64,       32'hC8);
        push_op(1, 32'hFFFF,     32'hFFFF);
        push_op(2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        push_op(3, 32'h0,        32'h12345678);
        drain(100);
        check_order("four_order", '{0, 1, 2, 3});

        // backpressure: hold rsp_ready low in DONE with req[1] pending
        rsp_ready = 1'b0;
        push_op(0, $urandom, $urandom);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            cyc();
            seen = rsp_valid;
        end
        check("bp_valid_seen", 64'(seen), 64'(1));
        push_op(1, $urandom, $urandom);
        repeat (5) cyc();
        rsp_ready = 1'b1;
        drain(100);

        // fairness: req[0] and req[2] held continuously
        do_reset();
        gq.delete();
        for (int i = 0; i < 3; i++) begin
            push_op(0, $urandom, $urandom);
            push_op(2, $urandom, $urandom);
        end
        drain(200);
        check_order("fair_order", '{0, 2, 0, 2, 0, 2});

        // reset mid-operation: ptr is 3 here, then reset restores ptr=0
        push_op(1, 32'hDEAD, 32'hBEEF);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            cyc();
            seen = (gnt != '0);
        end
        check("mid_gnt_seen", 64'(seen), 64'(1));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        gq.delete();
        push_op(3, 32'h3, 32'h7);
        push_op(0, 32'h5, 32'h9);
        drain(100);
        check_order("post_rst_order", '{0, 3});

        // randomized traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            cyc();
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                int r;
                r = int'($urandom_range(0, NR - 1));
                if (tl[r] - hd[r] < 4 && tl[r] < QD) begin
                    case ($urandom_range(0, 3))
                        0:       push_op(r, 32'hFFFFFFFF, $urandom);
                        1:       push_op(r, 32'h0, $urandom);
                        default: push_op(r, $urandom, $urandom);
                    endcase
                end
            end
        end
        rsp_ready = 1'b1;
        drain(400);

        // MUL_LAT=1 corner on the second instance
        cyc();
        l1_req             = 4'b0001;
        l1_req_a[31:0]     = 32'hFFFFFFFF;
        l1_req_b[31:0]     = 32'hFFFFFFFF;
        @(negedge clk);
        check("l1_gnt_pre",   64'(l1_gnt),       64'h0);
        @(negedge clk);
        check("l1_gnt",       64'(l1_gnt),       64'h1);
        check("l1_busy",      64'(l1_busy),      64'h1);
        check("l1_valid_gnt", 64'(l1_rsp_valid), 64'h0);
        check("l1_mul_a",     64'(l1_mul_a),     64'hFFFFFFFF);
        cyc();
        l1_req = '0;
        @(negedge clk);
        check("l1_valid",     64'(l1_rsp_valid), 64'h1);
        check("l1_rsp_c",     l1_rsp_c,          64'hFFFFFFFE00000001);
        check("l1_rsp_id",    64'(l1_rsp_id),    64'h0);
        check("l1_gnt_off",   64'(l1_gnt),       64'h0);
        @(negedge clk);
        check("l1_valid_off", 64'(l1_rsp_valid), 64'h0);
        check("l1_op_count",  64'(l1_op_count),  64'h1);
        check("l1_busy_off",  64'(l1_busy),      64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pm32_share_ctrl.md
# pm32_share_ctrl

Round-robin controller that shares one combinational `pm32` 32x32 unsigned multiplier among NREQ requesters. The controller latches the winning requester's operands into registers that drive the `pm32` inputs. It holds them stable for MUL_LAT cycles, which makes the multiplier a declared multicycle path. It then captures the 64-bit product and returns it with a valid/ready handshake. It sits between the requesting datapath units and a single `pm32` instance, which is external and wired to `mul_a`/`mul_b`/`mul_c`.

## Interface
- NREQ, 4: number of requesters, 2..8.
- MUL_LAT, 2: cycles the operands are held before the product is captured; must be ≥1 (0 is illegal).
- IDW, $clog2(NREQ): requester ID width.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; must stay high with stable operands until its `gnt` bit is seen.
- req_a  in  NREQ*32  operand A, requester i at bits [32i+31:32i].
- req_b  in  NREQ*32  operand B, same packing.
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of that requester were taken.
- mul_a  out  32  registered operand to pm32 `a`.
- mul_b  out  32  registered operand to pm32 `b`.
- mul_c  in  64  product from pm32 `c`.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  ID of the requester that owns `rsp_c`.
- rsp_c  out  64  registered product.
- busy  out  1  high in any state other than IDLE.
- op_count  out  32  completed (accepted) operations; wraps modulo 2^32.

## Operation
- States: IDLE, HOLD, DONE.
- **IDLE**, when any `req` bit is high at an edge:
  - Pick the winner w: the first set bit searching from `ptr` upward, wrapping modulo NREQ.
  - Register `mul_a`/`mul_b` from w's operands, set `gnt` to the one-hot of w, set `rsp_id` to w, set `cnt` to MUL_LAT-1, go to HOLD.
- **IDLE**, with no request: outputs are unchanged and `gnt` is 0.
- **HOLD**:
  - `mul_a` and `mul_b` are frozen.
  - Each edge: if `cnt`==0, capture `rsp_c`=`mul_c`, set `rsp_valid`=1 and go to DONE; otherwise decrement `cnt`.
  - `req` inputs are ignored.
- **DONE**:
  - `rsp_valid`, `rsp_c` and `rsp_id` are held stable while `rsp_ready` is 0.
  - On an edge with `rsp_ready`=1: clear `rsp_valid`, set `ptr` to (w+1) mod NREQ, increment `op_count`, go to IDLE.
- `gnt` is high only in the cycle after the grant edge, and 0 at all other times.
- A requester may keep `req` high during the `gnt` cycle to queue another operation. It competes again at the next IDLE edge.
- Arithmetic: `rsp_c` = `mul_a` * `mul_b`, unsigned, full 64 bits, no truncation.
- `mul_a` and `mul_b` keep their last values in IDLE and DONE and are not zeroed.
- `req` bits at positions ≥ NREQ do not exist; `ptr` never exceeds NREQ-1.

## Timing
- Reset values: state=IDLE, `ptr`=0, `cnt`=0, `gnt`=0, `mul_a`=0, `mul_b`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_c`=0, `busy`=0, `op_count`=0.
- Grant edge G: `gnt` and new `mul_a`/`mul_b` are visible in cycle G+1.
- `rsp_valid` rises at edge G+MUL_LAT, so the operands are stable for MUL_LAT full cycles before capture.
- With `rsp_ready` tied high:
  - `rsp_valid` is high for exactly 1 cycle.
  - The next grant edge is no earlier than G+MUL_LAT+2.
  - Sustained throughput is one operation per MUL_LAT+2 cycles.
- `busy` is registered alongside the state: high from cycle G+1 until the cycle after the accept edge.
- `rst` has priority over every other event, including accept and grant on the same edge.
- Reset in HOLD or DONE abandons the operation: no response is issued and `op_count` is not incremented.
- `op_count` wraps from 0xFFFFFFFF to 0.

## Test plan
- **Single request:** MUL_LAT=2, `req`[0] with a=0x1, b=0x2, `rsp_ready`=1. Expect `gnt`=0001 for one cycle, `rsp_valid` 2 cycles later with `rsp_c`=0x2 and `rsp_id`=0, then `op_count`=1.
- **Four simultaneous requests:**
  - Operands: (0x64,0xC8), (0xFFFF,0xFFFF), (0xFFFFFFFF,0xFFFFFFFF), (0x0,0x12345678).
  - Expect grant order 0,1,2,3.
  - Expect results 0x4E20, 0xFFFE0001, 0xFFFFFFFE00000001, 0x0.
  - Expect grants spaced exactly MUL_LAT+2 cycles apart.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles in DONE. Expect `rsp_valid`, `rsp_c` and `rsp_id` stable, `gnt` stays 0 despite pending `req`[1], and `op_count` is unchanged until the accept edge.
- **Fairness:** `req`[0] and `req`[2] held continuously. Expect grants alternating 0,2,0,2; `req`[1] and `req`[3] never granted.
- **Reset mid-operation:** assert `rst` one cycle into HOLD. Next cycle all outputs are at reset values, no `rsp_valid` pulse occurs, and a new request after release is granted with `ptr`=0 priority.
- **MUL_LAT=1 corner:** expect `rsp_valid` one cycle after the `gnt` pulse, with the correct product for a=b=0xFFFFFFFF.
